// File: rtl/debounce_multi.sv
// Multi-channel debouncer: per-channel synchroniser and stability counter,
// paced by one shared prescaler tick, with registered edge pulses.
module debounce_multi #(
  parameter int N_CH        = 4,
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 10,
  parameter int PRESCALE_W  = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic [CNT_W-1:0] i_thresh,
  input  logic [N_CH-1:0]  i_din,
  output logic [N_CH-1:0]  o_dout,
  output logic [N_CH-1:0]  o_onhigh,
  output logic [N_CH-1:0]  o_onlow,
  output logic             o_any
);

  logic [N_CH-1:0]       sync_q [SYNC_STAGES];
  logic [N_CH-1:0]       sync_s;
  logic [PRESCALE_W-1:0] pre_q, pre_d;
  logic                  tick;
  logic [CNT_W-1:0]      cntr_q [N_CH];
  logic [CNT_W-1:0]      cntr_d [N_CH];
  logic [N_CH-1:0]       dout_q, dout_d;
  logic [N_CH-1:0]       onhigh_q, onhigh_d;
  logic [N_CH-1:0]       onlow_q, onlow_d;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
    end else begin
      sync_q[0] <= i_din;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
    end
  end

  assign sync_s = sync_q[SYNC_STAGES-1];

  // One tick per full prescaler revolution; a frozen enable stalls every channel.
  assign pre_d = i_en ? pre_q + PRESCALE_W'(1) : pre_q;
  assign tick  = i_en & (&pre_q);

  always_comb begin
    dout_d   = dout_q;
    onhigh_d = '0;
    onlow_d  = '0;
    cntr_d   = cntr_q;
    for (int i = 0; i < N_CH; i++) begin
      if (sync_s[i] == dout_q[i]) begin
        cntr_d[i] = '0;
      end else if (tick) begin
        // >= lets a lowered threshold commit on the very next tick.
        if (cntr_q[i] >= i_thresh) begin
          dout_d[i]   = sync_s[i];
          cntr_d[i]   = '0;
          onhigh_d[i] = sync_s[i];
          onlow_d[i]  = ~sync_s[i];
        end else begin
          cntr_d[i] = cntr_q[i] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pre_q    <= '0;
      dout_q   <= '0;
      onhigh_q <= '0;
      onlow_q  <= '0;
      for (int i = 0; i < N_CH; i++) cntr_q[i] <= '0;
    end else begin
      pre_q    <= pre_d;
      dout_q   <= dout_d;
      onhigh_q <= onhigh_d;
      onlow_q  <= onlow_d;
      for (int i = 0; i < N_CH; i++) cntr_q[i] <= cntr_d[i];
    end
  end

  assign o_dout   = dout_q;
  assign o_onhigh = onhigh_q;
  assign o_onlow  = onlow_q;
  assign o_any    = |{onhigh_q, onlow_q};

endmodule
